// File: rtl/ofdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ofdm_pkg
//  Description : Shared constants and types for the OFDM symbol path
//                (QPSK modem -> symbol buffer -> IFFT).
//  Revision    : 1.0  initial release
// ============================================================================
package ofdm_pkg;

  // Width of each signed I/Q component, matching the modem output.
  localparam int OFDM_DATA_W = 24;
  // Subcarriers per OFDM frame (power of two, at least 2).
  localparam int OFDM_N_SC   = 8;
  // Width of a subcarrier index.
  localparam int OFDM_IDX_W  = $clog2(OFDM_N_SC);

  // One constellation point.
  typedef struct packed {
    logic signed [OFDM_DATA_W-1:0] x;
    logic signed [OFDM_DATA_W-1:0] y;
  } iq_t;

  // QPSK levels shared with the modem.
  localparam logic signed [OFDM_DATA_W-1:0] QPSK_POS = {{(OFDM_DATA_W-1){1'b0}}, 1'b1};
  localparam logic signed [OFDM_DATA_W-1:0] QPSK_NEG = {OFDM_DATA_W{1'b1}};

endpackage : ofdm_pkg
`default_nettype wire

// File: rtl/ofdm_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ofdm_bank_ctrl
//  Description : Ping-pong bank bookkeeping for the OFDM symbol buffer:
//                full flags, write/read bank pointers and indices, handshake
//                flags, sticky overflow and drained-frame counter.
//  Revision    : 1.0  initial release
// ============================================================================
module ofdm_bank_ctrl
  import ofdm_pkg::*;
#(
  parameter int N_SC  = OFDM_N_SC,
  parameter int IDX_W = $clog2(N_SC)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic             out_ready_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic             wr_en_o,
  output logic             wr_bank_o,
  output logic [IDX_W-1:0] wr_idx_o,
  output logic             rd_bank_o,
  output logic [IDX_W-1:0] rd_idx_o,
  output logic             overflow_o,
  output logic [15:0]      frame_cnt_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SC - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic in_ready;
  logic out_valid;
  logic wr_fire;
  logic rd_fire;

  // Handshake flags come only from registered state, so in_ready never
  // depends combinationally on out_ready.
  assign in_ready  = ~full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign wr_fire   = in_valid_i & in_ready;
  assign rd_fire   = out_valid & out_ready_i;

  // Next-state: read and write touch different banks, so both may complete
  // on the same edge; flush overrides everything.
  always_comb begin
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    wr_idx_d    = wr_idx_q;
    rd_bank_d   = rd_bank_q;
    rd_idx_d    = rd_idx_q;
    overflow_d  = overflow_q;
    frame_cnt_d = frame_cnt_q;

    if (rd_fire) begin
      if (rd_idx_q == LAST_IDX) begin
        full_d[rd_bank_q] = 1'b0;
        rd_idx_d          = '0;
        rd_bank_d         = ~rd_bank_q;
        frame_cnt_d       = frame_cnt_q + 16'd1;
      end else begin
        rd_idx_d = rd_idx_q + IDX_ONE;
      end
    end

    if (wr_fire) begin
      if (wr_idx_q == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_idx_d          = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + IDX_ONE;
      end
    end

    // The modem cannot stall: a symbol offered to a full bank is lost.
    if (in_valid_i && !in_ready) begin
      overflow_d = 1'b1;
    end

    if (flush_i) begin
      full_d      = '0;
      wr_bank_d   = 1'b0;
      wr_idx_d    = '0;
      rd_bank_d   = 1'b0;
      rd_idx_d    = '0;
      overflow_d  = 1'b0;
      frame_cnt_d = '0;
    end
  end

  // Bookkeeping registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
      overflow_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_bank_q   <= rd_bank_d;
      rd_idx_q    <= rd_idx_d;
      overflow_q  <= overflow_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid;
  assign wr_en_o     = wr_fire;
  assign wr_bank_o   = wr_bank_q;
  assign wr_idx_o    = wr_idx_q;
  assign rd_bank_o   = rd_bank_q;
  assign rd_idx_o    = rd_idx_q;
  assign overflow_o  = overflow_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule : ofdm_bank_ctrl
`default_nettype wire

// File: rtl/ofdm_symbol_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : ofdm_symbol_buffer
//  Description : Ping-pong double buffer that collects serial QPSK points into
//                OFDM frames and drains them to the IFFT over valid/ready.
//                Symbols arriving while both banks are full are dropped and
//                flagged through a sticky overflow bit.
//  Revision    : 1.0  initial release
// ============================================================================
module ofdm_symbol_buffer
  import ofdm_pkg::*;
#(
  parameter int DATA_W = OFDM_DATA_W,
  parameter int N_SC   = OFDM_N_SC,
  parameter int IDX_W  = $clog2(N_SC)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  input  logic signed [DATA_W-1:0] in_x_i,
  input  logic signed [DATA_W-1:0] in_y_i,
  output logic                     in_ready_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic signed [DATA_W-1:0] out_x_o,
  output logic signed [DATA_W-1:0] out_y_o,
  output logic [IDX_W-1:0]         out_idx_o,
  output logic                     out_first_o,
  output logic                     out_last_o,
  output logic                     overflow_o,
  output logic [15:0]              frame_cnt_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SC - 1);

  typedef struct packed {
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] y;
  } entry_t;

  entry_t bank_q [2][N_SC];

  logic             wr_en;
  logic             wr_bank;
  logic [IDX_W-1:0] wr_idx;
  logic             rd_bank;
  logic [IDX_W-1:0] rd_idx;
  logic             out_valid;
  entry_t           rd_entry;

  ofdm_bank_ctrl #(
    .N_SC  (N_SC),
    .IDX_W (IDX_W)
  ) u_bank_ctrl (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .out_ready_i (out_ready_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid),
    .wr_en_o     (wr_en),
    .wr_bank_o   (wr_bank),
    .wr_idx_o    (wr_idx),
    .rd_bank_o   (rd_bank),
    .rd_idx_o    (rd_idx),
    .overflow_o  (overflow_o),
    .frame_cnt_o (frame_cnt_o)
  );

  // Symbol storage: cleared on reset and flush (flush beats a concurrent
  // write), otherwise captures each accepted symbol at the write pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N_SC; i++) begin
          bank_q[b][i] <= '0;
        end
      end
    end else if (flush_i) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N_SC; i++) begin
          bank_q[b][i] <= '0;
        end
      end
    end else if (wr_en) begin
      bank_q[wr_bank][wr_idx] <= {in_x_i, in_y_i};
    end
  end

  // Output mux straight from registers; a stalled read leaves rd_idx and
  // therefore the presented symbol unchanged.
  assign rd_entry    = bank_q[rd_bank][rd_idx];
  assign out_valid_o = out_valid;
  assign out_x_o     = rd_entry.x;
  assign out_y_o     = rd_entry.y;
  assign out_idx_o   = rd_idx;
  assign out_first_o = out_valid & (rd_idx == '0);
  assign out_last_o  = out_valid & (rd_idx == LAST_IDX);

endmodule : ofdm_symbol_buffer
`default_nettype wire

// File: tb/tb_ofdm_symbol_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ofdm_symbol_buffer
//  Description : Self-checking bench for ofdm_symbol_buffer. A queue-based
//                frame model tracks what the buffer must present; directed
//                scenarios pin the model with literal expectations, then a
//                randomized run exercises the handshakes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ofdm_symbol_buffer;
  import ofdm_pkg::*;

  localparam int DW = OFDM_DATA_W;
  localparam int NS = OFDM_N_SC;
  localparam int IW = OFDM_IDX_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n     = 1'b0;
  logic                 flush     = 1'b0;
  logic                 in_valid  = 1'b0;
  logic signed [DW-1:0] in_x      = '0;
  logic signed [DW-1:0] in_y      = '0;
  logic                 out_ready = 1'b0;
  logic                 in_ready;
  logic                 out_valid;
  logic signed [DW-1:0] out_x;
  logic signed [DW-1:0] out_y;
  logic [IW-1:0]        out_idx;
  logic                 out_first;
  logic                 out_last;
  logic                 overflow;
  logic [15:0]          frame_cnt;

  ofdm_symbol_buffer dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_x_i      (in_x),
    .in_y_i      (in_y),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_x_o     (out_x),
    .out_y_o     (out_y),
    .out_idx_o   (out_idx),
    .out_first_o (out_first),
    .out_last_o  (out_last),
    .overflow_o  (overflow),
    .frame_cnt_o (frame_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: completed frames waiting to drain live in done_q as a
  // flat symbol list (a multiple of NS long); part_q holds the frame being
  // collected. Two stored frames means no room for input.
  // --------------------------------------------------------------------------
  iq_t         done_q[$];
  iq_t         part_q[$];
  int          rd_pos      = 0;
  bit          m_ovf       = 1'b0;
  logic [15:0] m_cnt       = '0;
  int          dual_events = 0;
  int          m_frames;
  bit          m_rdy, m_vld, m_rd_done, m_wr_done;

  function automatic void model_clear();
    done_q.delete();
    part_q.delete();
    rd_pos = 0;
    m_ovf  = 1'b0;
    m_cnt  = '0;
  endfunction

  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin
    if (rst_n) begin
      if (flush) begin
        model_clear();
      end else begin
        m_frames  = done_q.size() / NS;
        m_rdy     = (m_frames < 2);
        m_vld     = (m_frames > 0);
        m_rd_done = 1'b0;
        m_wr_done = 1'b0;
        if (m_vld && out_ready) begin
          rd_pos++;
          if (rd_pos == NS) begin
            repeat (NS) void'(done_q.pop_front());
            rd_pos    = 0;
            m_cnt     = m_cnt + 16'd1;
            m_rd_done = 1'b1;
          end
        end
        if (in_valid) begin
          if (m_rdy) begin
            part_q.push_back('{x: in_x, y: in_y});
            if (part_q.size() == NS) begin
              foreach (part_q[i]) done_q.push_back(part_q[i]);
              part_q.delete();
              m_wr_done = 1'b1;
            end
          end else begin
            m_ovf = 1'b1;
          end
        end
        if (m_rd_done && m_wr_done) dual_events++;
      end
    end
  end

  // Cycle-by-cycle comparison on the falling edge, away from register updates.
  int c_frames;
  bit c_vld;
  always @(negedge clk) begin
    if (rst_n) begin
      c_frames = done_q.size() / NS;
      c_vld    = (c_frames > 0);
      check("in_ready",  64'(in_ready),  64'(c_frames < 2));
      check("out_valid", 64'(out_valid), 64'(c_vld));
      check("out_idx",   64'(out_idx),   64'(rd_pos));
      check("out_first", 64'(out_first), 64'(c_vld && rd_pos == 0));
      check("out_last",  64'(out_last),  64'(c_vld && rd_pos == NS - 1));
      check("overflow",  64'(overflow),  64'(m_ovf));
      check("frame_cnt", 64'(frame_cnt), 64'(m_cnt));
      if (c_vld) begin
        check("out_x", 64'(out_x), 64'(done_q[rd_pos].x));
        check("out_y", 64'(out_y), 64'(done_q[rd_pos].y));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers. Every task starts and ends 2 time units after a rising
  // edge; inputs set here are consumed by the next rising edge.
  // --------------------------------------------------------------------------
  function automatic logic signed [DW-1:0] qx(input int i);
    return ((i % 4) == 0 || (i % 4) == 3) ? QPSK_POS : QPSK_NEG;
  endfunction

  function automatic logic signed [DW-1:0] qy(input int i);
    return ((i % 4) == 0 || (i % 4) == 2) ? QPSK_POS : QPSK_NEG;
  endfunction

  task automatic drive(input bit v, input logic signed [DW-1:0] x,
                       input logic signed [DW-1:0] y, input bit r);
    in_valid  = v;
    in_x      = x;
    in_y      = y;
    out_ready = r;
    @(posedge clk);
    #2;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    flush = 1'b0;
  endtask

  function automatic logic signed [DW-1:0] rnd_data();
    return DW'($urandom);
  endfunction

  initial begin
    // Power-on reset.
    model_clear();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    check("rst in_ready",  64'(in_ready),  64'(1));
    check("rst out_valid", 64'(out_valid), 64'(0));
    check("rst out_x",     64'(out_x),     64'(0));
    check("rst out_y",     64'(out_y),     64'(0));
    check("rst out_idx",   64'(out_idx),   64'(0));
    check("rst first/last", 64'({out_first, out_last}), 64'(0));
    check("rst overflow",  64'(overflow),  64'(0));
    check("rst frame_cnt", 64'(frame_cnt), 64'(0));

    // One QPSK frame, read back in order.
    for (int i = 0; i < NS; i++) begin
      if (i == NS - 1) check("t1 valid before last write", 64'(out_valid), 64'(0));
      drive(1'b1, qx(i), qy(i), 1'b1);
    end
    check("t1 valid after last write", 64'(out_valid), 64'(1));
    for (int i = 0; i < NS; i++) begin
      check("t1 idx",   64'(out_idx),   64'(i));
      check("t1 x",     64'(out_x),     64'(qx(i)));
      check("t1 y",     64'(out_y),     64'(qy(i)));
      check("t1 first", 64'(out_first), 64'(i == 0));
      check("t1 last",  64'(out_last),  64'(i == NS - 1));
      drive(1'b0, '0, '0, 1'b1);
    end
    check("t1 frame_cnt", 64'(frame_cnt), 64'(1));
    check("t1 overflow",  64'(overflow),  64'(0));
    check("t1 drained",   64'(out_valid), 64'(0));

    // Both banks full, then one dropped symbol, then drain both frames.
    do_flush();
    check("t2 flush frame_cnt", 64'(frame_cnt), 64'(0));
    for (int i = 0; i < 2 * NS; i++) drive(1'b1, rnd_data(), rnd_data(), 1'b0);
    check("t2 both full in_ready",  64'(in_ready),  64'(0));
    check("t2 both full out_valid", 64'(out_valid), 64'(1));
    check("t2 no overflow yet",     64'(overflow),  64'(0));
    drive(1'b1, rnd_data(), rnd_data(), 1'b0);
    check("t2 overflow", 64'(overflow), 64'(1));
    for (int i = 0; i < 2 * NS; i++) drive(1'b0, '0, '0, 1'b1);
    check("t2 frame_cnt", 64'(frame_cnt), 64'(2));
    check("t2 in_ready",  64'(in_ready),  64'(1));
    check("t2 out_valid", 64'(out_valid), 64'(0));

    // Stalled reads every other cycle.
    do_flush();
    for (int i = 0; i < NS; i++) drive(1'b1, rnd_data(), rnd_data(), 1'b0);
    for (int i = 0; i < 2 * NS; i++) drive(1'b0, '0, '0, (i % 2) == 0);
    check("t3 frame_cnt", 64'(frame_cnt), 64'(1));
    check("t3 drained",   64'(out_valid), 64'(0));

    // Ten frames streamed with continuous output acceptance.
    do_flush();
    for (int i = 0; i < 10 * NS; i++) drive(1'b1, rnd_data(), rnd_data(), 1'b1);
    for (int i = 0; i < NS; i++) drive(1'b0, '0, '0, 1'b1);
    check("t4 overflow",  64'(overflow),  64'(0));
    check("t4 frame_cnt", 64'(frame_cnt), 64'(10));
    check("t4 same-edge complete seen", 64'(dual_events > 0), 64'(1));

    // Asynchronous reset in the middle of a partial frame.
    for (int i = 0; i < 5; i++) drive(1'b1, rnd_data(), rnd_data(), 1'b0);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("t5 async out_valid", 64'(out_valid), 64'(0));
    check("t5 async in_ready",  64'(in_ready),  64'(1));
    check("t5 async frame_cnt", 64'(frame_cnt), 64'(0));
    check("t5 async out_idx",   64'(out_idx),   64'(0));
    check("t5 async out_xy",    64'({out_x, out_y}), 64'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < NS; i++) drive(1'b1, qx(i + 1), qy(i + 1), 1'b0);
    check("t5 clean frame valid", 64'(out_valid), 64'(1));
    check("t5 clean frame idx",   64'(out_idx),   64'(0));
    check("t5 clean frame x0",    64'(out_x),     64'(qx(1)));
    for (int i = 0; i < NS; i++) drive(1'b0, '0, '0, 1'b1);
    check("t5 frame_cnt", 64'(frame_cnt), 64'(1));

    // Flush with a concurrent symbol: the symbol is lost, state cleared.
    for (int i = 0; i < 2 * NS + 1; i++) drive(1'b1, qx(i), qy(i), 1'b0);
    check("t6 pre-flush overflow", 64'(overflow), 64'(1));
    flush = 1'b1;
    drive(1'b1, 24'sd77, 24'sd77, 1'b1);
    flush = 1'b0;
    check("t6 out_valid", 64'(out_valid), 64'(0));
    check("t6 in_ready",  64'(in_ready),  64'(1));
    check("t6 overflow",  64'(overflow),  64'(0));
    check("t6 frame_cnt", 64'(frame_cnt), 64'(0));
    for (int i = 0; i < NS; i++) drive(1'b1, qx(i + 2), qy(i + 2), 1'b0);
    check("t6 first after flush idx", 64'(out_idx), 64'(0));
    check("t6 first after flush x",   64'(out_x),   64'(qx(2)));
    check("t6 first after flush y",   64'(out_y),   64'(qy(2)));

    // Randomized traffic with rare flushes.
    for (int i = 0; i < 800; i++) begin
      flush = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) != 0, rnd_data(), rnd_data(), $urandom_range(0, 1) == 1);
    end
    flush = 1'b0;
    for (int i = 0; i < 2 * NS + 2; i++) drive(1'b0, '0, '0, 1'b1);
    check("rand drained", 64'(out_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ofdm_symbol_buffer
`default_nettype wire
